// File: rtl/bus_sel_pkg.sv
// Shared constants for the datapath bus-source select logic: source indices
// as seen by the 32-bit bus multiplexer and the arbitration mode selectors.
package bus_sel_pkg;

  // Source index constants; req[i] encodes to select code i.
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  // Arbitration modes.
  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;

endpackage

// File: rtl/bus_source_arbiter_prio_pick.sv
// Combinational find-first-set over an N-bit vector, searching upward from a
// start offset and wrapping past N-1 back to 0. Codes >= N are never produced.
module prio_pick #(
  parameter int N = 24,
  parameter int W = 5
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);

  int w_base;
  int w_pos;

  // Rotating scan: the first set bit at or after start wins, with wrap.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    idx    = '0;
    any    = 1'b0;
    w_pos  = 0;
    w_base = (int'(start) < N) ? int'(start) : 0;
    for (int i = 0; i < N; i++) begin
      w_pos = w_base + i;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!any && vec[w_pos]) begin
        any = 1'b1;
        idx = W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Registered bus-source arbiter: turns the control unit's <src>out strobes
// into a bus-mux select code, with fixed-priority or round-robin choice,
// a grant lock for multi-cycle transfers and multiple-driver detection.
module bus_source_arbiter
  import bus_sel_pkg::*;
#(
  parameter int N_SRC = 24,
  parameter int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  parameter int RR    = ARB_FIXED,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [N_SRC-1:0] req,
  input  logic             lock,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid,
  output logic             multi,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} lock_state_e;

  lock_state_e      r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_sel_valid;
  logic             r_multi;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_rr_ptr;

  logic [SEL_W-1:0] w_start;
  logic [SEL_W-1:0] w_idx;
  logic             w_any;
  logic [SEL_W-1:0] w_next_ptr;
  logic             w_multi;
  logic             w_hold;
  logic             w_cnt_sat;

  // Fixed priority always searches from source 0.
  assign w_start = (RR == ARB_RR) ? r_rr_ptr : '0;

  prio_pick #(
    .N (N_SRC),
    .W (SEL_W)
  ) u_pick (
    .vec   (req),
    .start (w_start),
    .idx   (w_idx),
    .any   (w_any)
  );

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi    = |(req & (req - N_SRC'(1)));
  assign w_next_ptr = (w_idx == SEL_W'(N_SRC - 1)) ? '0 : w_idx + SEL_W'(1);
  assign w_cnt_sat  = &r_cnt;
  // A locked grant survives only while lock stays up and its own source still drives.
  assign w_hold     = (r_state == LOCKED) && lock && req[r_sel];

  // Grant/lock FSM with registered select, conflict flag and event counter.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    if (clr) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_multi     <= 1'b0;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
    end else if (en) begin
      r_multi <= w_multi;
      if (w_multi && !w_cnt_sat) r_cnt <= r_cnt + CNT_W'(1);
      if (!w_hold) begin
        if (w_any) begin
          r_sel       <= w_idx;
          r_sel_valid <= 1'b1;
          r_state     <= lock ? LOCKED : GRANT;
          if (RR == ARB_RR) r_rr_ptr <= w_next_ptr;
        end else begin
          r_sel_valid <= 1'b0;
          r_state     <= IDLE;
        end
      end
    end
  end

  assign sel          = r_sel;
  assign sel_valid    = r_sel_valid;
  assign multi        = r_multi;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Bench for bus_source_arbiter. Three instances share one stimulus stream:
// fixed priority (defaults), round-robin, and a 2-bit saturating counter.
// Each table row drives one cycle and names the instance whose outputs it
// predicts; the prediction is queued at drive time and popped one edge later.
module tb_bus_source_arbiter;
  import bus_sel_pkg::*;

  typedef struct {
    int          dut;
    logic        clr;
    logic        en;
    logic        lock;
    logic [23:0] req;
    logic [4:0]  sel;
    logic        valid;
    logic        multi;
    logic [7:0]  cnt;
  } vec_t;

  typedef struct {
    int         id;
    int         dut;
    logic [4:0] sel;
    logic       valid;
    logic       multi;
    logic [7:0] cnt;
  } exp_t;

  localparam int D_FIX = 0;
  localparam int D_RR  = 1;
  localparam int D_SAT = 2;

  logic        clk  = 1'b0;
  logic        clr  = 1'b1;
  logic        en   = 1'b0;
  logic        lock = 1'b0;
  logic [23:0] req  = '0;

  logic [4:0] f_sel, r_sel, s_sel;
  logic       f_val, r_val, s_val;
  logic       f_mul, r_mul, s_mul;
  logic [7:0] f_cnt, r_cnt;
  logic [1:0] s_cnt;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bus_source_arbiter #(.RR(ARB_FIXED)) dut_fix (
    .clk(clk), .clr(clr), .en(en), .req(req), .lock(lock),
    .sel(f_sel), .sel_valid(f_val), .multi(f_mul), .conflict_cnt(f_cnt)
  );

  bus_source_arbiter #(.RR(ARB_RR)) dut_rr (
    .clk(clk), .clr(clr), .en(en), .req(req), .lock(lock),
    .sel(r_sel), .sel_valid(r_val), .multi(r_mul), .conflict_cnt(r_cnt)
  );

  bus_source_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .clr(clr), .en(en), .req(req), .lock(lock),
    .sel(s_sel), .sel_valid(s_val), .multi(s_mul), .conflict_cnt(s_cnt)
  );

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, id, act, exp);
    end
  endtask

  function automatic vec_t mk(input int dut, input logic c, input logic e,
                              input logic l, input logic [23:0] r, input int s,
                              input logic v, input logic m, input int cnt);
    vec_t t;
    t.dut = dut; t.clr = c; t.en = e; t.lock = l; t.req = r;
    t.sel = 5'(s); t.valid = v; t.multi = m; t.cnt = 8'(cnt);
    return t;
  endfunction

  // Scoreboard consumer: one edge after a row is driven, its prediction is due.
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t       e;
      logic [4:0] a_sel;
      logic       a_val, a_mul;
      logic [7:0] a_cnt;
      e = sb.pop_front();
      case (e.dut)
        D_FIX:   begin a_sel = f_sel; a_val = f_val; a_mul = f_mul; a_cnt = f_cnt; end
        D_RR:    begin a_sel = r_sel; a_val = r_val; a_mul = r_mul; a_cnt = r_cnt; end
        default: begin a_sel = s_sel; a_val = s_val; a_mul = s_mul; a_cnt = {6'd0, s_cnt}; end
      endcase
      check("sel",       e.id, 32'(a_sel), 32'(e.sel));
      check("sel_valid", e.id, 32'(a_val), 32'(e.valid));
      check("multi",     e.id, 32'(a_mul), 32'(e.multi));
      check("cnt",       e.id, 32'(a_cnt), 32'(e.cnt));
    end
  end

  initial begin
    //                dut    clr   en    lock  req           sel v  m  cnt
    // Reset with every strobe high: all outputs zero.
    tbl.push_back(mk(D_FIX, 1'b1, 1'b1, 1'b0, 24'hFFFFFF,  0, 0, 0, 0));
    tbl.push_back(mk(D_SAT, 1'b1, 1'b1, 1'b0, 24'hFFFFFF,  0, 0, 0, 0));
    // Fixed priority: R0+R2 -> 0; Cout alone -> 23; idle keeps sel; en=0 holds.
    tbl.push_back(mk(D_FIX, 1'b0, 1'b1, 1'b0, 24'h000005,  0, 1, 1, 1));
    tbl.push_back(mk(D_FIX, 1'b0, 1'b1, 1'b0, 24'h800000, 23, 1, 0, 1));
    tbl.push_back(mk(D_FIX, 1'b0, 1'b1, 1'b0, 24'h000000, 23, 0, 0, 1));
    tbl.push_back(mk(D_FIX, 1'b0, 1'b0, 1'b0, 24'h000000, 23, 0, 0, 1));
    // Round-robin wrap between sources 0 and 23.
    tbl.push_back(mk(D_RR,  1'b1, 1'b1, 1'b0, 24'h800001,  0, 0, 0, 0));
    tbl.push_back(mk(D_RR,  1'b0, 1'b1, 1'b0, 24'h800001,  0, 1, 1, 1));
    tbl.push_back(mk(D_RR,  1'b0, 1'b1, 1'b0, 24'h800001, 23, 1, 1, 2));
    tbl.push_back(mk(D_RR,  1'b0, 1'b1, 1'b0, 24'h800001,  0, 1, 1, 3));
    tbl.push_back(mk(D_RR,  1'b0, 1'b1, 1'b0, 24'h800001, 23, 1, 1, 4));
    // Lock sequence on fixed priority: R5 keeps the bus against R1.
    tbl.push_back(mk(D_FIX, 1'b1, 1'b1, 1'b0, 24'h000000,  0, 0, 0, 0));
    tbl.push_back(mk(D_FIX, 1'b0, 1'b1, 1'b1, 24'h000020,  5, 1, 0, 0));
    tbl.push_back(mk(D_FIX, 1'b0, 1'b1, 1'b1, 24'h000022,  5, 1, 1, 1));
    tbl.push_back(mk(D_FIX, 1'b0, 1'b1, 1'b1, 24'h000002,  1, 1, 0, 1));
    tbl.push_back(mk(D_FIX, 1'b0, 1'b1, 1'b1, 24'h000020,  5, 1, 0, 1));
    // Dropping lock releases and re-arbitrates; round-robin view of same cycle.
    tbl.push_back(mk(D_RR,  1'b0, 1'b1, 1'b0, 24'h000022,  1, 1, 1, 2));
    // Lock rise with two requesters: RR winner (5) gets locked, then holds.
    tbl.push_back(mk(D_RR,  1'b0, 1'b1, 1'b1, 24'h000022,  5, 1, 1, 3));
    tbl.push_back(mk(D_RR,  1'b0, 1'b1, 1'b1, 24'h000022,  5, 1, 1, 4));
    tbl.push_back(mk(D_RR,  1'b0, 1'b1, 1'b0, 24'h000022,  1, 1, 1, 5));
    // Counter saturation on the 2-bit instance.
    tbl.push_back(mk(D_SAT, 1'b1, 1'b1, 1'b0, 24'h000003,  0, 0, 0, 0));
    tbl.push_back(mk(D_SAT, 1'b0, 1'b1, 1'b0, 24'h000003,  0, 1, 1, 1));
    tbl.push_back(mk(D_SAT, 1'b0, 1'b1, 1'b0, 24'h000003,  0, 1, 1, 2));
    tbl.push_back(mk(D_SAT, 1'b0, 1'b1, 1'b0, 24'h000003,  0, 1, 1, 3));
    tbl.push_back(mk(D_SAT, 1'b0, 1'b1, 1'b0, 24'h000003,  0, 1, 1, 3));
    tbl.push_back(mk(D_SAT, 1'b0, 1'b1, 1'b0, 24'h000003,  0, 1, 1, 3));
    // en=0 with a conflicting request that would otherwise pick source 4.
    tbl.push_back(mk(D_SAT, 1'b0, 1'b0, 1'b0, 24'h000030,  0, 1, 1, 3));
    tbl.push_back(mk(D_FIX, 1'b0, 1'b0, 1'b0, 24'h000030,  0, 1, 1, 5));
    // Reset mid-locked transfer; next grant searches from pointer 0 (2, not 7).
    tbl.push_back(mk(D_RR,  1'b0, 1'b1, 1'b1, 24'h000020,  5, 1, 0, 5));
    tbl.push_back(mk(D_RR,  1'b1, 1'b1, 1'b1, 24'h000084,  0, 0, 0, 0));
    tbl.push_back(mk(D_RR,  1'b0, 1'b1, 1'b1, 24'h000084,  2, 1, 1, 1));

    foreach (tbl[i]) begin
      exp_t e;
      @(negedge clk);
      clr  = tbl[i].clr;
      en   = tbl[i].en;
      lock = tbl[i].lock;
      req  = tbl[i].req;
      e.id = i; e.dut = tbl[i].dut; e.sel = tbl[i].sel;
      e.valid = tbl[i].valid; e.multi = tbl[i].multi; e.cnt = tbl[i].cnt;
      sb.push_back(e);
    end

    @(negedge clk);
    en  = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", -1, 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
